// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush controller and its mul/div sequencer.
package pipeline_ctrl_pkg;

    typedef logic [1:0] md_state_t;

    localparam md_state_t MD_IDLE = 2'd0;
    localparam md_state_t MD_BUSY = 2'd1;
    localparam md_state_t MD_DONE = 2'd2;

    localparam int MULT_CYCLES_DEF = 4;
    localparam int DIV_CYCLES_DEF  = 33;
    localparam int CNT_W_DEF       = 6;

    // Register 0 is hard-wired zero, so a load targeting it never creates a hazard.
    function automatic logic load_use_hit(input logic       rd_mem,
                                          input logic [4:0] dst,
                                          input logic [4:0] rs,
                                          input logic [4:0] rt);
        return rd_mem && (dst != 5'd0) && ((dst == rs) || (dst == rt));
    endfunction

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Hazard inputs from the pipeline stages and the enables/flushes/strobes returned to them.
interface pipeline_ctrl_if;
    logic [4:0] ID_rs;
    logic [4:0] ID_rt;
    logic       EXE_ReadMem;
    logic [4:0] EXE_Dst;
    logic       EXE_BranchTaken;
    logic       EXE_MulDivReq;
    logic       EXE_IsDiv;
    logic       MEM_ExceptValid;
    logic       IF_PCWr;
    logic       IF_IDWr;
    logic       IDEXE_Wr;
    logic       IFID_Flush;
    logic       IDEXE_Flush;
    logic       EXEMEM_Flush;
    logic       MulDiv_Start;
    logic       MulDiv_Abort;
    logic       HILO_Wr;
    logic       MulDiv_Busy;

    modport master (
        output ID_rs, ID_rt, EXE_ReadMem, EXE_Dst, EXE_BranchTaken,
               EXE_MulDivReq, EXE_IsDiv, MEM_ExceptValid,
        input  IF_PCWr, IF_IDWr, IDEXE_Wr, IFID_Flush, IDEXE_Flush, EXEMEM_Flush,
               MulDiv_Start, MulDiv_Abort, HILO_Wr, MulDiv_Busy
    );

    modport slave (
        input  ID_rs, ID_rt, EXE_ReadMem, EXE_Dst, EXE_BranchTaken,
               EXE_MulDivReq, EXE_IsDiv, MEM_ExceptValid,
        output IF_PCWr, IF_IDWr, IDEXE_Wr, IFID_Flush, IDEXE_Flush, EXEMEM_Flush,
               MulDiv_Start, MulDiv_Abort, HILO_Wr, MulDiv_Busy
    );
endinterface

// File: rtl/pipeline_ctrl_muldiv_seq.sv
// IDLE/BUSY/DONE sequencer for the iterative HILO mul/div unit: start, latency count,
// result strobe, and abort when an exception commits.
module pipeline_ctrl_muldiv_seq
    import pipeline_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
    parameter int CNT_W       = CNT_W_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic req_i,
    input  logic is_div_i,
    input  logic except_i,
    output logic start_o,
    output logic abort_o,
    output logic hilo_wr_o,
    output logic stall_o,
    output logic busy_o
);

    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

    md_state_t         state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    // Next-state and latency counter; an exception always returns to IDLE.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (except_i) begin
            state_d = MD_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                MD_IDLE: begin
                    if (req_i) begin
                        state_d = MD_BUSY;
                        cnt_d   = is_div_i ? DIV_LOAD : MULT_LOAD;
                    end else begin
                        state_d = MD_IDLE;
                    end
                end
                MD_BUSY: begin
                    if (cnt_q == '0) begin
                        state_d = MD_DONE;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                MD_DONE: state_d = MD_IDLE;
                default: begin
                    state_d = MD_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= MD_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // The request in DONE belongs to the finishing instruction, so only IDLE may start.
    assign start_o   = ~rst & ~except_i & (state_q == MD_IDLE) & req_i;
    assign abort_o   = ~rst & except_i & ((state_q == MD_BUSY) | (state_q == MD_DONE));
    assign hilo_wr_o = ~rst & ~except_i & (state_q == MD_DONE);
    assign stall_o   = ~except_i & (((state_q == MD_IDLE) & req_i) | (state_q == MD_BUSY));
    assign busy_o    = ~rst & (state_q != MD_IDLE);

endmodule

// File: rtl/pipeline_ctrl.sv
// Central stall/flush controller: merges exception, branch, mul/div and load-use
// conditions by priority into the pipeline write enables and flushes.
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
    parameter int CNT_W       = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    pipeline_ctrl_if.slave    bus
);

    logic md_stall_s;
    logic load_use_s;
    logic pc_wr_s, ifid_wr_s, idexe_wr_s;
    logic ifid_fl_s, idexe_fl_s, exemem_fl_s;

    pipeline_ctrl_muldiv_seq #(
        .MULT_CYCLES (MULT_CYCLES),
        .DIV_CYCLES  (DIV_CYCLES),
        .CNT_W       (CNT_W)
    ) u_seq (
        .clk       (clk),
        .rst       (rst),
        .req_i     (bus.EXE_MulDivReq),
        .is_div_i  (bus.EXE_IsDiv),
        .except_i  (bus.MEM_ExceptValid),
        .start_o   (bus.MulDiv_Start),
        .abort_o   (bus.MulDiv_Abort),
        .hilo_wr_o (bus.HILO_Wr),
        .stall_o   (md_stall_s),
        .busy_o    (bus.MulDiv_Busy)
    );

    assign load_use_s = load_use_hit(bus.EXE_ReadMem, bus.EXE_Dst, bus.ID_rs, bus.ID_rt);

    // Priority merge: reset, exception, branch, mul/div stall, load-use.
    always_comb begin
        pc_wr_s     = 1'b1;
        ifid_wr_s   = 1'b1;
        idexe_wr_s  = 1'b1;
        ifid_fl_s   = 1'b0;
        idexe_fl_s  = 1'b0;
        exemem_fl_s = 1'b0;
        if (rst) begin
            pc_wr_s     = 1'b0;
            ifid_wr_s   = 1'b0;
            idexe_wr_s  = 1'b0;
            ifid_fl_s   = 1'b1;
            idexe_fl_s  = 1'b1;
            exemem_fl_s = 1'b1;
        end else if (bus.MEM_ExceptValid) begin
            ifid_fl_s   = 1'b1;
            idexe_fl_s  = 1'b1;
            exemem_fl_s = 1'b1;
        end else if (bus.EXE_BranchTaken) begin
            ifid_fl_s   = 1'b1;
            idexe_fl_s  = 1'b1;
        end else if (md_stall_s) begin
            pc_wr_s     = 1'b0;
            ifid_wr_s   = 1'b0;
            idexe_wr_s  = 1'b0;
            exemem_fl_s = 1'b1;
        end else if (load_use_s) begin
            pc_wr_s     = 1'b0;
            ifid_wr_s   = 1'b0;
            idexe_fl_s  = 1'b1;
        end else begin
            exemem_fl_s = 1'b0;
        end
    end

    assign bus.IF_PCWr      = pc_wr_s;
    assign bus.IF_IDWr      = ifid_wr_s;
    assign bus.IDEXE_Wr     = idexe_wr_s;
    assign bus.IFID_Flush   = ifid_fl_s;
    assign bus.IDEXE_Flush  = idexe_fl_s;
    assign bus.EXEMEM_Flush = exemem_fl_s;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl with default latencies (MULT 4, DIV 33).
module tb_pipeline_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    pipeline_ctrl_if bus();

    pipeline_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // {PCWr, IF_IDWr, IDEXE_Wr, IFID_Fl, IDEXE_Fl, EXEMEM_Fl, Start, Abort, HILO_Wr, Busy}
    logic [9:0] outs;
    assign outs = {bus.IF_PCWr, bus.IF_IDWr, bus.IDEXE_Wr,
                   bus.IFID_Flush, bus.IDEXE_Flush, bus.EXEMEM_Flush,
                   bus.MulDiv_Start, bus.MulDiv_Abort, bus.HILO_Wr, bus.MulDiv_Busy};

    localparam logic [9:0] E_DEF      = 10'b111_000_0000;
    localparam logic [9:0] E_RST      = 10'b000_111_0000;
    localparam logic [9:0] E_REQ      = 10'b000_001_1000;
    localparam logic [9:0] E_BUSY     = 10'b000_001_0001;
    localparam logic [9:0] E_DONE     = 10'b111_000_0011;
    localparam logic [9:0] E_LU       = 10'b001_010_0000;
    localparam logic [9:0] E_BR       = 10'b111_110_0000;
    localparam logic [9:0] E_EXC_BUSY = 10'b111_111_0101;
    localparam logic [9:0] E_EXC_IDLE = 10'b111_111_0000;

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic rdmem, input logic [4:0] dst, input logic [4:0] rs,
                          input logic [4:0] rt, input logic br, input logic req,
                          input logic isdiv, input logic exc);
        bus.EXE_ReadMem     = rdmem;
        bus.EXE_Dst         = dst;
        bus.ID_rs           = rs;
        bus.ID_rt           = rt;
        bus.EXE_BranchTaken = br;
        bus.EXE_MulDivReq   = req;
        bus.EXE_IsDiv       = isdiv;
        bus.MEM_ExceptValid = exc;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (outs !== E_RST) begin errors++; $display("FAIL reset_hold0 got=%b exp=%b", outs, E_RST); end
        next_cycle();
        checks++;
        if (outs !== E_RST) begin errors++; $display("FAIL reset_hold1 got=%b exp=%b", outs, E_RST); end
        next_cycle();
        rst = 1'b0;
        #1;
        checks++;
        if (outs !== E_DEF) begin errors++; $display("FAIL reset_release got=%b exp=%b", outs, E_DEF); end
    endtask

    task automatic test_load_use();
        next_cycle();
        set_in(1'b1, 5'd5, 5'd1, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (outs !== E_LU) begin errors++; $display("FAIL lu_rt got=%b exp=%b", outs, E_LU); end
        next_cycle();
        set_in(1'b1, 5'd9, 5'd9, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (outs !== E_LU) begin errors++; $display("FAIL lu_rs got=%b exp=%b", outs, E_LU); end
        next_cycle();
        set_in(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (outs !== E_DEF) begin errors++; $display("FAIL lu_dst0 got=%b exp=%b", outs, E_DEF); end
        next_cycle();
        set_in(1'b0, 5'd5, 5'd5, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (outs !== E_DEF) begin errors++; $display("FAIL lu_noload got=%b exp=%b", outs, E_DEF); end
        next_cycle();
        set_in(1'b1, 5'd7, 5'd5, 5'd6, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (outs !== E_DEF) begin errors++; $display("FAIL lu_nomatch got=%b exp=%b", outs, E_DEF); end
    endtask

    task automatic test_mult();
        next_cycle();
        set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        checks++;
        if (outs !== E_REQ) begin errors++; $display("FAIL mult_req got=%b exp=%b", outs, E_REQ); end
        for (int k = 1; k <= 4; k++) begin
            next_cycle();
            checks++;
            if (outs !== E_BUSY) begin errors++; $display("FAIL mult_busy%0d got=%b exp=%b", k, outs, E_BUSY); end
        end
        next_cycle();
        checks++;
        if (outs !== E_DONE) begin errors++; $display("FAIL mult_done got=%b exp=%b", outs, E_DONE); end
        next_cycle();
        set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (outs !== E_DEF) begin errors++; $display("FAIL mult_after got=%b exp=%b", outs, E_DEF); end
    endtask

    task automatic test_div_abort();
        next_cycle();
        set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0);
        checks++;
        if (outs !== E_REQ) begin errors++; $display("FAIL div_req got=%b exp=%b", outs, E_REQ); end
        for (int k = 1; k <= 6; k++) begin
            next_cycle();
            checks++;
            if (outs !== E_BUSY) begin errors++; $display("FAIL div_busy%0d got=%b exp=%b", k, outs, E_BUSY); end
        end
        next_cycle();
        set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1);
        checks++;
        if (outs !== E_EXC_BUSY) begin errors++; $display("FAIL div_abort got=%b exp=%b", outs, E_EXC_BUSY); end
        next_cycle();
        set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (outs !== E_DEF) begin errors++; $display("FAIL div_abort_idle got=%b exp=%b", outs, E_DEF); end
        for (int k = 0; k < 34; k++) begin
            next_cycle();
            checks++;
            if (outs !== E_DEF) begin errors++; $display("FAIL div_abort_quiet%0d got=%b exp=%b", k, outs, E_DEF); end
        end
    endtask

    task automatic test_except_done();
        next_cycle();
        set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int k = 1; k <= 4; k++) next_cycle();
        next_cycle();
        set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1);
        checks++;
        if (outs !== E_EXC_BUSY) begin errors++; $display("FAIL exc_in_done got=%b exp=%b", outs, E_EXC_BUSY); end
        next_cycle();
        set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (outs !== E_DEF) begin errors++; $display("FAIL exc_done_idle got=%b exp=%b", outs, E_DEF); end
    endtask

    task automatic test_back_to_back();
        int stall_div = 0;
        int stall_mul = 0;
        next_cycle();
        set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0);
        checks++;
        if (outs !== E_REQ) begin errors++; $display("FAIL b2b_div_req got=%b exp=%b", outs, E_REQ); end
        if (!bus.IF_PCWr) stall_div++;
        for (int k = 1; k <= 33; k++) begin
            next_cycle();
            if (!bus.IF_PCWr) stall_div++;
            checks++;
            if (outs !== E_BUSY) begin errors++; $display("FAIL b2b_div_busy%0d got=%b exp=%b", k, outs, E_BUSY); end
        end
        next_cycle();
        checks++;
        if (outs !== E_DONE) begin errors++; $display("FAIL b2b_div_done got=%b exp=%b", outs, E_DONE); end
        checks++;
        if (stall_div !== 34) begin errors++; $display("FAIL b2b_div_stall got=%0d exp=34", stall_div); end
        next_cycle();
        set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        checks++;
        if (outs !== E_REQ) begin errors++; $display("FAIL b2b_mul_req got=%b exp=%b", outs, E_REQ); end
        if (!bus.IF_PCWr) stall_mul++;
        for (int k = 1; k <= 4; k++) begin
            next_cycle();
            if (!bus.IF_PCWr) stall_mul++;
            checks++;
            if (outs !== E_BUSY) begin errors++; $display("FAIL b2b_mul_busy%0d got=%b exp=%b", k, outs, E_BUSY); end
        end
        next_cycle();
        checks++;
        if (outs !== E_DONE) begin errors++; $display("FAIL b2b_mul_done got=%b exp=%b", outs, E_DONE); end
        checks++;
        if (stall_mul !== 5) begin errors++; $display("FAIL b2b_mul_stall got=%0d exp=5", stall_mul); end
        next_cycle();
        set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (outs !== E_DEF) begin errors++; $display("FAIL b2b_after got=%b exp=%b", outs, E_DEF); end
    endtask

    task automatic test_branch();
        next_cycle();
        set_in(1'b1, 5'd5, 5'd0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
        checks++;
        if (outs !== E_BR) begin errors++; $display("FAIL br_over_lu got=%b exp=%b", outs, E_BR); end
        next_cycle();
        set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b1);
        checks++;
        if (outs !== E_EXC_IDLE) begin errors++; $display("FAIL exc_over_all got=%b exp=%b", outs, E_EXC_IDLE); end
        next_cycle();
        set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (outs !== E_DEF) begin errors++; $display("FAIL exc_no_start got=%b exp=%b", outs, E_DEF); end
        next_cycle();
        set_in(1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        checks++;
        if (outs !== E_REQ) begin errors++; $display("FAIL md_over_lu_req got=%b exp=%b", outs, E_REQ); end
        next_cycle();
        checks++;
        if (outs !== E_BUSY) begin errors++; $display("FAIL md_over_lu_busy got=%b exp=%b", outs, E_BUSY); end
        for (int k = 2; k <= 5; k++) next_cycle();
        next_cycle();
        set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (outs !== E_DEF) begin errors++; $display("FAIL md_over_lu_drain got=%b exp=%b", outs, E_DEF); end
    endtask

    task automatic test_reset_mid_busy();
        next_cycle();
        set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0);
        for (int k = 1; k <= 22; k++) next_cycle();
        next_cycle();
        checks++;
        if (dut.u_seq.cnt_q !== 6'd10) begin errors++; $display("FAIL rst_mid_cnt got=%0d exp=10", dut.u_seq.cnt_q); end
        rst = 1'b1;
        #1;
        checks++;
        if (outs !== E_RST) begin errors++; $display("FAIL rst_mid0 got=%b exp=%b", outs, E_RST); end
        next_cycle();
        checks++;
        if (outs !== E_RST) begin errors++; $display("FAIL rst_mid1 got=%b exp=%b", outs, E_RST); end
        next_cycle();
        rst = 1'b0;
        set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (outs !== E_DEF) begin errors++; $display("FAIL rst_mid_release got=%b exp=%b", outs, E_DEF); end
        next_cycle();
        checks++;
        if (outs !== E_DEF) begin errors++; $display("FAIL rst_mid_idle got=%b exp=%b", outs, E_DEF); end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_mult();
        test_div_abort();
        test_except_done();
        test_back_to_back();
        test_branch();
        test_reset_mid_busy();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
